// File: rtl/fpro_mailbox_pkg.sv
// fpro_mailbox_pkg
// Shared constants for the FPro mailbox slot core: register offsets within
// the slot, bit positions inside the status and control words, and a helper
// that assembles the control readback word.
// No ports (package).
package fpro_mailbox_pkg;

    // Word offsets within the MMIO slot
    localparam logic [4:0] REG_RX_DATA = 5'd0;
    localparam logic [4:0] REG_STATUS  = 5'd1;
    localparam logic [4:0] REG_TX_DATA = 5'd2;
    localparam logic [4:0] REG_CTRL    = 5'd3;

    // Status word bit positions
    localparam int STAT_RX_EMPTY     = 0;
    localparam int STAT_RX_FULL      = 1;
    localparam int STAT_TX_EMPTY     = 2;
    localparam int STAT_TX_FULL      = 3;
    localparam int STAT_RX_COUNT_LSB = 8;
    localparam int STAT_TX_COUNT_LSB = 16;

    // Control write bit positions
    localparam int CTRL_FLUSH_RX     = 0;
    localparam int CTRL_FLUSH_TX     = 1;
    localparam int CTRL_CLEAR_STICKY = 2;
    localparam int CTRL_IRQ_EN_RX    = 8;
    localparam int CTRL_IRQ_EN_TX    = 9;

    // Control readback bit positions for the sticky flags
    localparam int FLAG_TX_OVERFLOW  = 0;
    localparam int FLAG_RX_UNDERFLOW = 1;

    // Builds the word returned by a read of the control offset. Builds
    // without interrupt support pass zero enables so bits [9:8] read 0.
    function automatic logic [31:0] ctrlReadback(input logic txOverflow,
                                                 input logic rxUnderflow,
                                                 input logic [1:0] irqEnable);
        logic [31:0] word;
        word = '0;
        word[FLAG_TX_OVERFLOW]  = txOverflow;
        word[FLAG_RX_UNDERFLOW] = rxUnderflow;
        word[CTRL_IRQ_EN_RX]    = irqEnable[0];
        word[CTRL_IRQ_EN_TX]    = irqEnable[1];
        return word;
    endfunction

endpackage

// File: rtl/mailbox_fifo.sv
// mailbox_fifo
// Synchronous FIFO of 2**DEPTH_LOG2 words used for both mailbox directions.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push_i, data_i      write request and data (ignored when full)
//   pop_i               read request (ignored when empty)
//   flush_i             empties the FIFO; overrides push and pop
//   data_o              head word, combinational from memory, 0 when empty
//   empty_o, full_o     occupancy flags from the registered count
//   count_o             number of stored words (DEPTH_LOG2+1 bits)
module mailbox_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    input  logic [WIDTH-1:0]      data_i,
    output logic [WIDTH-1:0]      data_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [DEPTH_LOG2:0]   count_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_DEPTH = DEPTH;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
    logic [DEPTH_LOG2-1:0] rdPtr_q, rdPtr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  doPush, doPop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_DEPTH);
    assign count_o = count_q;

    // Full/empty come from pre-edge state, so a push to a full FIFO is
    // dropped even if a pop happens in the same cycle.
    assign doPush = push_i && !full_o && !flush_i;
    assign doPop  = pop_i && !empty_o && !flush_i;

    // Gating the head with empty keeps the output at 0 after reset and on
    // an underflowing read, without having to reset the memory.
    assign data_o = empty_o ? '0 : mem[rdPtr_q];

    // Next-state pointers and count; flush wins over everything.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) wrPtr_d = wrPtr_q + PTR_ONE;
            if (doPop)  rdPtr_d = rdPtr_q + PTR_ONE;
            case ({doPush, doPop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; stale words are never visible because the head
    // is masked while empty.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr_q] <= data_i;
    end

endmodule

// File: rtl/fpro_mailbox.sv
// fpro_mailbox
// FPro-bus MMIO slot core giving the CPU a TX and an RX FIFO of 32-bit words
// toward a valid/ready streaming peripheral. Zero-wait-state responses.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   cs, read, write, addr, wr_data MMIO slot bus from the controller
//   rd_data                        read data, 0 unless cs && read
//   tx_data, tx_valid, tx_ready    outbound stream (TX FIFO head)
//   rx_data, rx_valid, rx_ready    inbound stream (into RX FIFO)
//   irq                            only with FPRO_MAILBOX_IRQ_EN defined
// Option macro FPRO_MAILBOX_IRQ_EN adds a registered interrupt output with
// enables in control bits [9:8] (rx_not_empty, tx_empty).
module fpro_mailbox
    import fpro_mailbox_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [31:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
`ifdef FPRO_MAILBOX_IRQ_EN
    ,
    output logic        irq
`endif
);

    logic                cpuRead, cpuWrite, ctrlWrite;
    logic                rxPop, txPush, flushRx, flushTx, clearSticky;
    logic                rxEmpty, rxFull, txEmpty, txFull;
    logic [DEPTH_LOG2:0] rxCount, txCount;
    logic [31:0]         rxHead, statusWord;
    logic                txOverflow_q, rxUnderflow_q;
    logic [1:0]          irqEnable;

    assign cpuRead     = cs && read;
    assign cpuWrite    = cs && write;
    assign ctrlWrite   = cpuWrite && (addr == REG_CTRL);
    assign rxPop       = cpuRead && (addr == REG_RX_DATA);
    assign txPush      = cpuWrite && (addr == REG_TX_DATA);
    assign flushRx     = ctrlWrite && wr_data[CTRL_FLUSH_RX];
    assign flushTx     = ctrlWrite && wr_data[CTRL_FLUSH_TX];
    assign clearSticky = ctrlWrite && wr_data[CTRL_CLEAR_STICKY];

    // Stream handshakes depend only on registered occupancy.
    assign tx_valid = !txEmpty;
    assign rx_ready = !rxFull;

    mailbox_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(32)) txFifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (txPush),
        .pop_i   (tx_ready),
        .flush_i (flushTx),
        .data_i  (wr_data),
        .data_o  (tx_data),
        .empty_o (txEmpty),
        .full_o  (txFull),
        .count_o (txCount)
    );

    mailbox_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(32)) rxFifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rx_valid),
        .pop_i   (rxPop),
        .flush_i (flushRx),
        .data_i  (rx_data),
        .data_o  (rxHead),
        .empty_o (rxEmpty),
        .full_o  (rxFull),
        .count_o (rxCount)
    );

    // Status word assembled from registered FIFO state.
    always_comb begin
        statusWord = '0;
        statusWord[STAT_RX_EMPTY] = rxEmpty;
        statusWord[STAT_RX_FULL]  = rxFull;
        statusWord[STAT_TX_EMPTY] = txEmpty;
        statusWord[STAT_TX_FULL]  = txFull;
        statusWord[STAT_RX_COUNT_LSB +: 8] = 8'(rxCount);
        statusWord[STAT_TX_COUNT_LSB +: 8] = 8'(txCount);
    end

    // Sticky error flags. Full/empty are sampled before the edge, and a
    // clear in the same cycle as a new error wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txOverflow_q  <= 1'b0;
            rxUnderflow_q <= 1'b0;
        end else if (clearSticky) begin
            txOverflow_q  <= 1'b0;
            rxUnderflow_q <= 1'b0;
        end else begin
            if (txPush && txFull) txOverflow_q  <= 1'b1;
            if (rxPop && rxEmpty) rxUnderflow_q <= 1'b1;
        end
    end

`ifdef FPRO_MAILBOX_IRQ_EN
    logic [1:0] irqEnable_q;
    logic       irq_q;

    assign irqEnable = irqEnable_q;
    assign irq       = irq_q;

    // Interrupt enables follow every control write; the request is the
    // registered OR of the enabled conditions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irqEnable_q <= 2'b00;
            irq_q       <= 1'b0;
        end else begin
            if (ctrlWrite) begin
                irqEnable_q <= {wr_data[CTRL_IRQ_EN_TX], wr_data[CTRL_IRQ_EN_RX]};
            end
            irq_q <= (irqEnable_q[0] && !rxEmpty) || (irqEnable_q[1] && txEmpty);
        end
    end
`else
    assign irqEnable = 2'b00;
`endif

    // Read mux; anything other than a qualified read returns 0, and reads of
    // the write-only TX offset or unused offsets also return 0.
    always_comb begin
        rd_data = '0;
        if (cpuRead) begin
            case (addr)
                REG_RX_DATA: rd_data = rxHead;
                REG_STATUS:  rd_data = statusWord;
                REG_CTRL:    rd_data = ctrlReadback(txOverflow_q, rxUnderflow_q, irqEnable);
                default:     rd_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_fpro_mailbox.sv
// tb_fpro_mailbox
// Self-checking bench for fpro_mailbox: directed scenarios with literal
// expectations, then randomized bus and stream traffic compared every cycle
// against a queue-based model of the mailbox.
module tb_fpro_mailbox;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst_n;
    logic        cs, read, write;
    logic [4:0]  addr;
    logic [31:0] wr_data, rd_data, tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, rx_ready;
`ifdef FPRO_MAILBOX_IRQ_EN
    logic        irq;
`endif

    int nVectors;
    int nMiscompares;
    bit checkEn;

    // Behavioural model: word queues plus the two sticky flags
    logic [31:0] txQ[$];
    logic [31:0] rxQ[$];
    bit          modelOvf, modelUnf;

    fpro_mailbox #(.DEPTH_LOG2(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs       (cs),
        .read     (read),
        .write    (write),
        .addr     (addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready)
`ifdef FPRO_MAILBOX_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one bus/stream cycle just after the rising edge.
    task automatic applyStimulus(input logic csV, input logic rdV, input logic wrV,
                                 input logic [4:0] a, input logic [31:0] d,
                                 input logic txr, input logic rxv,
                                 input logic [31:0] rxd);
        @(posedge clk);
        #1;
        cs = csV; read = rdV; write = wrV; addr = a; wr_data = d;
        tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    endtask

    function automatic logic [31:0] modelStatus();
        logic [31:0] s;
        int rxN, txN;
        rxN = rxQ.size();
        txN = txQ.size();
        s = '0;
        s[0] = (rxN == 0);
        s[1] = (rxN == DEPTH);
        s[2] = (txN == 0);
        s[3] = (txN == DEPTH);
        s[15:8]  = 8'(rxN);
        s[23:16] = 8'(txN);
        return s;
    endfunction

    function automatic logic [31:0] modelReadData();
        logic [31:0] r;
        r = '0;
        if (cs && read) begin
            if (addr == 5'd0)      r = (rxQ.size() > 0) ? rxQ[0] : 32'h0;
            else if (addr == 5'd1) r = modelStatus();
            else if (addr == 5'd3) r = {30'b0, modelUnf, modelOvf};
        end
        return r;
    endfunction

    // Advances the model across one rising edge using the current inputs.
    task automatic updateModel();
        bit ctrlWr, flushRx, flushTx, clr, txFullPre, rxEmptyPre, txHasPre;
        ctrlWr     = cs && write && (addr == 5'd3);
        flushRx    = ctrlWr && wr_data[0];
        flushTx    = ctrlWr && wr_data[1];
        clr        = ctrlWr && wr_data[2];
        txFullPre  = (txQ.size() == DEPTH);
        txHasPre   = (txQ.size() > 0);
        rxEmptyPre = (rxQ.size() == 0);

        if (clr) begin
            modelOvf = 0;
            modelUnf = 0;
        end else begin
            if (cs && write && addr == 5'd2 && txFullPre) modelOvf = 1;
            if (cs && read && addr == 5'd0 && rxEmptyPre) modelUnf = 1;
        end

        if (flushTx) txQ.delete();
        else begin
            if (tx_ready && txHasPre) void'(txQ.pop_front());
            if (cs && write && addr == 5'd2 && !txFullPre) txQ.push_back(wr_data);
        end

        if (flushRx) rxQ.delete();
        else begin
            bit rxFullPre;
            rxFullPre = (rxQ.size() == DEPTH);
            if (cs && read && addr == 5'd0 && !rxEmptyPre) void'(rxQ.pop_front());
            if (rx_valid && !rxFullPre) rxQ.push_back(rx_data);
        end
    endtask

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        if (checkEn && rst_n) begin
            checkOutput("rd_data",  rd_data,         modelReadData());
            checkOutput("tx_valid", {31'b0, tx_valid}, {31'b0, txQ.size() > 0});
            checkOutput("tx_data",  tx_data,         (txQ.size() > 0) ? txQ[0] : 32'h0);
            checkOutput("rx_ready", {31'b0, rx_ready}, {31'b0, rxQ.size() < DEPTH});
            updateModel();
        end
    end

    initial begin
        nVectors = 0; nMiscompares = 0; checkEn = 0;
        modelOvf = 0; modelUnf = 0;
        rst_n = 1'b0;
        cs = 0; read = 0; write = 0; addr = '0; wr_data = '0;
        tx_ready = 0; rx_valid = 0; rx_data = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        checkEn = 1;

        // Reset state
        applyStimulus(1, 1, 0, 5'd1, 0, 0, 0, 0);
        #1;
        checkOutput("reset_status", rd_data, 32'h0000_0005);
        checkOutput("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
        checkOutput("reset_rx_ready", {31'b0, rx_ready}, 32'h1);
        checkOutput("reset_tx_data", tx_data, 32'h0);

        // Three TX words held back, then drained one per cycle
        for (int i = 1; i <= 3; i++) applyStimulus(1, 0, 1, 5'd2, 32'hA5A5_0000 + i, 0, 0, 0);
        applyStimulus(1, 1, 0, 5'd1, 0, 0, 0, 0);
        #1 checkOutput("tx_count3_status", rd_data, 32'h0003_0001);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
            #1 checkOutput("tx_drain_data", tx_data, 32'hA5A5_0000 + i);
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        #1 checkOutput("tx_drain_done", {31'b0, tx_valid}, 32'h0);

        // Overflow on a full TX, then sticky clear
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 1, 5'd2, $urandom, 0, 0, 0);
        applyStimulus(1, 0, 1, 5'd2, 32'hDEAD_BEEF, 0, 0, 0);
        applyStimulus(1, 1, 0, 5'd1, 0, 0, 0, 0);
        #1 checkOutput("tx_full_status", rd_data, 32'h0010_0009);
        applyStimulus(1, 1, 0, 5'd3, 0, 0, 0, 0);
        #1 checkOutput("overflow_flag", rd_data, 32'h0000_0001);
        applyStimulus(1, 0, 1, 5'd3, 32'h4, 0, 0, 0);
        applyStimulus(1, 1, 0, 5'd3, 0, 0, 0, 0);
        #1 checkOutput("sticky_cleared", rd_data, 32'h0);

        // Flush TX: empty, count 0, no overflow
        applyStimulus(1, 0, 1, 5'd3, 32'h2, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 1, 5'd2, 32'h5000 + i, 0, 0, 0);
        applyStimulus(1, 1, 0, 5'd1, 0, 0, 0, 0);
        #1 checkOutput("tx_five_status", rd_data, 32'h0005_0001);
        applyStimulus(1, 0, 1, 5'd3, 32'h2, 0, 0, 0);
        applyStimulus(1, 1, 0, 5'd1, 0, 0, 0, 0);
        #1 checkOutput("tx_flushed_status", rd_data, 32'h0000_0005);
        applyStimulus(1, 1, 0, 5'd3, 0, 0, 0, 0);
        #1 checkOutput("flush_no_overflow", rd_data, 32'h0);

        // Fill RX from the stream, drain in order, then underflow
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h100 + i);
        applyStimulus(1, 1, 0, 5'd1, 0, 0, 0, 0);
        #1;
        checkOutput("rx_full_ready", {31'b0, rx_ready}, 32'h0);
        checkOutput("rx_full_status", rd_data, 32'h0000_1006);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1, 1, 0, 5'd0, 0, 0, 0, 0);
            #1 checkOutput("rx_pop_data", rd_data, 32'h100 + i);
        end
        applyStimulus(1, 1, 0, 5'd0, 0, 0, 0, 0);
        #1 checkOutput("rx_underflow_data", rd_data, 32'h0);
        applyStimulus(1, 1, 0, 5'd3, 0, 0, 0, 0);
        #1 checkOutput("underflow_flag", rd_data, 32'h0000_0002);
        applyStimulus(1, 0, 1, 5'd3, 32'h4, 0, 0, 0);

        // Asynchronous reset between edges with both FIFOs occupied
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 5'd2, 32'h7000 + i, 0, 1, 32'h8000 + i);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        txQ.delete(); rxQ.delete(); modelOvf = 0; modelUnf = 0;
        #1 rst_n = 1'b1;
        cs = 1; read = 1; addr = 5'd1;
        #1;
        checkOutput("async_reset_status", rd_data, 32'h0000_0005);
        checkOutput("async_reset_tx_valid", {31'b0, tx_valid}, 32'h0);
        checkOutput("async_reset_rx_ready", {31'b0, rx_ready}, 32'h1);

        // Randomized traffic; TX readiness alternates bias to reach full/empty
        for (int cyc = 0; cyc < 2000; cyc++) begin
            int sel, rw, txBias;
            logic [4:0]  a;
            logic [31:0] d;
            sel = $urandom_range(0, 9);
            rw  = $urandom_range(0, 2);
            if (sel <= 2)      a = 5'd0;
            else if (sel <= 4) a = 5'd1;
            else if (sel <= 7) a = 5'd2;
            else if (sel == 8) a = 5'd3;
            else               a = 5'($urandom_range(4, 31));
            d = $urandom;
            if (a == 5'd3 && $urandom_range(0, 3) != 0) d = d & 32'hFFFF_FFFC;
            txBias = ((cyc / 250) % 2 == 0) ? 1 : 3;
            applyStimulus(rw != 2, rw == 0, rw == 1, a, d,
                          $urandom_range(0, 3) < txBias,
                          $urandom_range(0, 3) < (4 - txBias), $urandom);
        end

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
